led_status_reporter: RTL and testbench

Transmit-side companion to the UART LED command decoder. That decoder toggles LEDs when it receives the ASCII characters '1'..'4'. This block reports the current LED state back to the host as an ASCII line, "L" followed by one '0'/'1' per LED (MSB first), then CR LF. It sits between the LED state register and the tx byte interface of a uart instance (send/tx_data), and sends a report on LED change, on host request, or periodically as a heartbeat.

---
 rtl/led_status_reporter_if.sv | 9 +
 rtl/led_status_reporter.sv | 135 +++++++++++++
 tb/tb_led_status_reporter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_status_reporter_if.sv
// Byte-level transmit handshake between the LED reporter and a uart transmitter.
interface led_status_reporter_if;
  logic       send;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output send, output tx_data, input tx_busy);
  modport slave  (input send, input tx_data, output tx_busy);
endinterface

// File: rtl/led_status_reporter.sv
// Reports the LED register to the host as "L<bits>\r\n" on change, on request or on a heartbeat.
// Bytes are strobed into a uart through the tx interface, one per idle period of tx_busy.
module led_status_reporter #(
  parameter int unsigned LEDS                 = 4,
  parameter int unsigned REPORT_PERIOD_CYCLES = 40000000,
  parameter int unsigned CNT_WIDTH            = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LEDS-1:0]       led_state_i,
  input  logic                  report_req_i,
  led_status_reporter_if.master tx,
  output logic                  active_o,
  output logic [15:0]           msg_count_o
);

  localparam int unsigned MsgLen = LEDS + 3;
  localparam int          IdxW   = $clog2(MsgLen);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(LEDS + 2);
  localparam bit                   HbEn    = (REPORT_PERIOD_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] HbLast  = CNT_WIDTH'(REPORT_PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGuard, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [LEDS-1:0]      snap_q, snap_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] hb_q, hb_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 active_q, active_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 send;
  logic                 hb_hit;
  logic                 trig;
  logic [7:0]           msg [MsgLen];
  logic [7:0]           cur_byte;

  // Message image is built from the snapshot only, so live LED changes never leak mid-message.
  always_comb begin
    msg[0] = 8'h4C;
    for (int k = 0; k < LEDS; k++) begin
      msg[k+1] = 8'h30 + {7'd0, snap_q[LEDS-1-k]};
    end
    msg[LEDS+1] = 8'h0D;
    msg[LEDS+2] = 8'h0A;
  end

  assign cur_byte = msg[idx_q];
  assign hb_hit   = HbEn && (hb_q == HbLast);
  assign trig     = (led_state_i != snap_q) || report_req_i || hb_hit;

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    pend_d   = pend_q | trig;
    hb_d     = hb_q;
    idx_d    = idx_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    send     = 1'b0;

    if (HbEn && (hb_q != HbLast)) begin
      hb_d = hb_q + CNT_WIDTH'(1);
    end

    case (state_q)
      StIdle: begin
        if (pend_q) state_d = StLoad;
      end
      StLoad: begin
        snap_d   = led_state_i;
        pend_d   = 1'b0;
        hb_d     = '0;
        idx_d    = '0;
        active_d = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
        if (!tx.tx_busy) begin
          send    = 1'b1;
          data_d  = cur_byte;
          state_d = StGuard;
        end
      end
      // The uart raises busy one cycle after the strobe, so skip sampling it here.
      StGuard: state_d = StWait;
      StWait: begin
        if (!tx.tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StSend;
          end
        end
      end
      StDone: begin
        cnt_d    = cnt_q + 16'd1;
        active_d = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      snap_q   <= '0;
      pend_q   <= 1'b0;
      hb_q     <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      hb_q     <= hb_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  assign tx.send      = send;
  assign tx.tx_data   = send ? cur_byte : data_q;
  assign active_o     = active_q;
  assign msg_count_o  = cnt_q;

endmodule

// File: tb/tb_led_status_reporter.sv
// Directed bench: scoreboarded byte stream on a heartbeat-free instance, plus a heartbeat instance.
module tb_led_status_reporter;

  logic        clk = 1'b0;
  logic        rst_n, rst_n_hb;
  logic [3:0]  led, led_hb;
  logic        report_req;
  logic        active, active_hb;
  logic [15:0] cnt, cnt_hb;
  logic        hold_busy = 1'b0;
  int          busy_cnt = 0;
  int          hb_busy_cnt = 0;

  always #5 clk = ~clk;

  led_status_reporter_if txif ();
  led_status_reporter_if hbif ();

  // Uart models: busy for 10 cycles starting the cycle after a strobe.
  always @(posedge clk) begin
    if (txif.send) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (hbif.send) hb_busy_cnt <= 10;
    else if (hb_busy_cnt > 0) hb_busy_cnt <= hb_busy_cnt - 1;
  end
  assign txif.tx_busy = hold_busy || (busy_cnt != 0);
  assign hbif.tx_busy = (hb_busy_cnt != 0);

  led_status_reporter #(.LEDS(4), .REPORT_PERIOD_CYCLES(0), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_state_i  (led),
    .report_req_i (report_req),
    .tx           (txif),
    .active_o     (active),
    .msg_count_o  (cnt)
  );

  led_status_reporter #(.LEDS(4), .REPORT_PERIOD_CYCLES(200), .CNT_WIDTH(8)) dut_hb (
    .clk          (clk),
    .rst_n        (rst_n_hb),
    .led_state_i  (led_hb),
    .report_req_i (1'b0),
    .tx           (hbif),
    .active_o     (active_hb),
    .msg_count_o  (cnt_hb)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q [$];
  int         byte_seen = 0;
  int         cyc = 0;
  int         hb_pos = 0;
  int         hb_lines = 0;
  int         hb_last_l = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic void push_msg(input logic [3:0] v);
    exp_q.push_back(8'h4C);
    for (int k = 3; k >= 0; k--) exp_q.push_back(8'h30 + {7'd0, v[k]});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic logic [7:0] hb_exp(input int p);
    if (p == 0) return 8'h4C;
    else if (p <= 4) return 8'h30;
    else if (p == 5) return 8'h0D;
    else return 8'h0A;
  endfunction

  always @(negedge clk) begin
    if (txif.send) begin
      byte_seen++;
      check("send_while_busy", txif.tx_busy, 0);
      check("active_during_send", active, 1);
      check("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_byte", txif.tx_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (hbif.send) begin
      check("hb_byte", hbif.tx_data, hb_exp(hb_pos));
      if (hb_pos == 0) begin
        check("hb_msg_count", cnt_hb, hb_lines);
        if (hb_last_l >= 0) begin
          check("hb_period", (cyc - hb_last_l >= 195) && (cyc - hb_last_l <= 210), 1);
        end
        hb_last_l = cyc;
      end
      if (hb_pos == 6) begin
        hb_pos = 0;
        hb_lines++;
      end else begin
        hb_pos++;
      end
    end
  end

  task automatic wait_msgs(input logic [15:0] target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cnt === target) break;
    end
    check(tag, cnt, target);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (byte_seen >= target) break;
    end
    check(tag, byte_seen >= target, 1);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
  endtask

  initial begin
    int base_b;
    int sends;
    rst_n      = 1'b0;
    rst_n_hb   = 1'b0;
    led        = 4'b0000;
    led_hb     = 4'b0000;
    report_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_send", txif.send, 0);
    check("rst_tx_data", txif.tx_data, 0);
    check("rst_active", active, 0);
    check("rst_msg_count", cnt, 0);
    check("rst_hb_msg_count", cnt_hb, 0);
    rst_n    = 1'b1;
    rst_n_hb = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", active, 0);

    // Single LED change gives exactly one message.
    push_msg(4'b0101);
    led = 4'b0101;
    wait_msgs(16'd1, 400, "change_msg_done");
    check("change_active_low", active, 0);
    check("change_queue_empty", exp_q.size(), 0);
    repeat (60) @(negedge clk);
    check("change_no_repeat", cnt, 1);

    // LED change mid-message: first message unchanged, follow-up carries the new value.
    base_b = byte_seen;
    push_msg(4'b0101);
    push_msg(4'b0111);
    pulse_req();
    wait_bytes(base_b + 3, 200, "mid_byte2_seen");
    led = 4'b0111;
    wait_msgs(16'd3, 600, "mid_two_msgs");
    check("mid_queue_empty", exp_q.size(), 0);

    // Request while the uart is busy must stall until busy drops.
    hold_busy = 1'b1;
    push_msg(4'b0111);
    pulse_req();
    sends = 0;
    repeat (50) begin
      @(negedge clk);
      if (txif.send) sends++;
    end
    check("busy_no_send", sends, 0);
    check("busy_active_waiting", active, 1);
    @(posedge clk);
    #1 hold_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txif.send) break;
    end
    check("busy_release_send", txif.send, 1);
    check("busy_release_byte", txif.tx_data, 8'h4C);
    wait_msgs(16'd4, 400, "busy_msg_done");

    // Request and LED change in the same cycle merge into one message.
    push_msg(4'b1111);
    @(negedge clk);
    led        = 4'b1111;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    wait_msgs(16'd5, 400, "merge_msg_done");
    repeat (80) @(negedge clk);
    check("merge_single_msg", cnt, 5);

    // Reset after byte 3 abandons the message; restart sends the new state from 'L'.
    base_b = byte_seen;
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    led = 4'b0011;
    wait_bytes(base_b + 4, 300, "rstmid_byte3_seen");
    rst_n = 1'b0;
    #1;
    check("rstmid_send", txif.send, 0);
    check("rstmid_tx_data", txif.tx_data, 0);
    check("rstmid_active", active, 0);
    check("rstmid_msg_count", cnt, 0);
    check("rstmid_queue_empty", exp_q.size(), 0);
    led = 4'b1000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_msg(4'b1000);
    wait_msgs(16'd1, 400, "rstmid_fresh_msg");
    check("rstmid_fresh_queue_empty", exp_q.size(), 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hb_lines >= 3) break;
    end
    check("hb_three_msgs", hb_lines >= 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
